// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-entry output buffer with valid/ready handshake and sticky error flags.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  input  logic       ERR_CLR,
  output logic       BUSY
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state, state_nxt;
  logic             rxd_p0, rxd_p1;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             half_done, bit_done;
  logic             deliver, frame_bad, buf_blocked, handshake;

  // Stage p0/p1: metastability synchronizer; rxd_p1 is the sampled line
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  assign half_done   = (cnt == HALF_LAST);
  assign bit_done    = (cnt == BIT_LAST);
  assign deliver     = (state == STOP) && bit_done && rxd_p1;
  assign frame_bad   = (state == STOP) && bit_done && !rxd_p1;
  assign handshake   = RX_VALID && RX_READY;
  assign buf_blocked = RX_VALID && !RX_READY;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxd_p1) state_nxt = START;
      START:     if (half_done) state_nxt = rxd_p1 ? IDLE : DATA;
      DATA:      if (bit_done && idx == 3'd7) state_nxt = STOP;
      STOP:      if (bit_done) state_nxt = rxd_p1 ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxd_p1) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      case (state)
        START: begin
          cnt <= half_done ? '0 : cnt + CNT_W'(1);
          idx <= '0;
        end
        DATA: begin
          cnt <= bit_done ? '0 : cnt + CNT_W'(1);
          if (bit_done) idx <= idx + 3'd1;
        end
        STOP:    cnt <= bit_done ? '0 : cnt + CNT_W'(1);
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == DATA && bit_done) shreg[idx] <= rxd_p1;
  end

  // Stage p2: output buffer; a delivery on the handshake edge refills it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RX_DATA   <= 8'h00;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (deliver && !buf_blocked) begin
        RX_DATA  <= shreg;
        RX_VALID <= 1'b1;
      end else if (handshake) begin
        RX_VALID <= 1'b0;
      end
      if (frame_bad)    FRAME_ERR <= 1'b1;
      else if (ERR_CLR) FRAME_ERR <= 1'b0;
      if (deliver && buf_blocked) OVERRUN <= 1'b1;
      else if (ERR_CLR)           OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 4 clocks per bit: directed scenarios plus random
// frames, checked every cycle against a frame-level model of the output buffer.
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RESET, RXD, RX_READY, ERR_CLR;
  logic [7:0] RX_DATA;
  logic       RX_VALID, FRAME_ERR, OVERRUN, BUSY;

  uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(250_000)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN),
    .ERR_CLR(ERR_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } dlv_t;

  dlv_t       dq[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         cyc = 0;
  bit         rnd_on = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // A frame whose start bit is driven just after edge e0 is decided at edge e0+41.
  task automatic send_frame(input logic [7:0] b, input bit stopb);
    dlv_t d;
    d.at = cyc + 41;
    d.b  = b;
    d.ok = stopb;
    dq.push_back(d);
    RXD = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(4);
    end
    RXD = stopb;
    tick(4);
  endtask

  // Model of the buffer and flags, then compare DUT outputs just after each edge.
  always @(posedge CLK) begin : cmp
    dlv_t d;
    bit   ev, hs, sfe, sov;
    cyc++;
    if (RESET) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      dq.delete();
    end else begin
      hs  = m_valid && RX_READY;
      sfe = 1'b0;
      sov = 1'b0;
      ev  = (dq.size() > 0) && (dq[0].at == cyc);
      if (ev) d = dq.pop_front();
      if (ev && !d.ok) sfe = 1'b1;
      if (ev && d.ok && m_valid && !hs) sov = 1'b1;
      if (ev && d.ok && !(m_valid && !hs)) begin
        m_data  = d.b;
        m_valid = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (sfe) m_fe = 1'b1;
      else if (ERR_CLR) m_fe = 1'b0;
      if (sov) m_ov = 1'b1;
      else if (ERR_CLR) m_ov = 1'b0;
    end
    #1;
    check("rx_valid", RX_VALID, m_valid);
    if (m_valid) check("rx_data", RX_DATA, m_data);
    check("frame_err", FRAME_ERR, m_fe);
    check("overrun", OVERRUN, m_ov);
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd_on) begin
        RX_READY = ($urandom_range(0, 2) != 0);
        ERR_CLR  = ($urandom_range(0, 15) == 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; RXD = 1'b1; RX_READY = 1'b1; ERR_CLR = 1'b0;
    tick(3);
    check("reset_busy", BUSY, 1'b0);
    check("reset_data", RX_DATA, 8'h00);
    RESET = 1'b0;
    tick(2);

    // 0xA5 with consumer ready
    send_frame(8'hA5, 1'b1);
    check("a5_busy_in_stop", BUSY, 1'b1);
    tick(1);
    check("a5_valid", RX_VALID, 1'b1);
    check("a5_data", RX_DATA, 8'hA5);
    check("a5_busy_after", BUSY, 1'b0);
    check("a5_fe", FRAME_ERR, 1'b0);
    tick(1);
    check("a5_valid_one_cycle", RX_VALID, 1'b0);
    tick(3);

    // one-cycle glitch is rejected in START
    RXD = 1'b0;
    tick(1);
    RXD = 1'b1;
    tick(2);
    check("glitch_busy", BUSY, 1'b1);
    tick(3);
    check("glitch_idle", BUSY, 1'b0);
    check("glitch_novalid", RX_VALID, 1'b0);
    tick(4);

    // framing error, line held low, then released and flag cleared
    send_frame(8'h3C, 1'b0);
    tick(12);
    check("fe_set", FRAME_ERR, 1'b1);
    check("fe_wait_busy", BUSY, 1'b1);
    check("fe_novalid", RX_VALID, 1'b0);
    RXD = 1'b1;
    tick(4);
    check("fe_back_idle", BUSY, 1'b0);
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
    check("fe_clr", FRAME_ERR, 1'b0);
    tick(2);

    // overrun: second byte dropped while first is held
    RX_READY = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    check("ov_data_held", RX_DATA, 8'h11);
    check("ov_flag", OVERRUN, 1'b1);
    RX_READY = 1'b1;
    tick(1);
    check("ov_drained", RX_VALID, 1'b0);
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
    check("ov_clr", OVERRUN, 1'b0);
    tick(2);

    // handshake on the delivery edge of the following byte
    RX_READY = 1'b0;
    send_frame(8'h55, 1'b1);
    fork
      send_frame(8'h66, 1'b1);
      begin
        tick(40);
        RX_READY = 1'b1;
        tick(1);
        RX_READY = 1'b0;
      end
    join
    check("same_edge_data", RX_DATA, 8'h66);
    check("same_edge_valid", RX_VALID, 1'b1);
    check("same_edge_ov", OVERRUN, 1'b0);
    RX_READY = 1'b1;
    tick(3);

    // reset during data bit 4 of 0xFF, then 0x81
    RXD = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      RXD = 1'b1;
      if (i < 4) tick(4);
    end
    tick(1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rst_busy", BUSY, 1'b0);
    check("rst_valid", RX_VALID, 1'b0);
    check("rst_data", RX_DATA, 8'h00);
    tick(3);
    send_frame(8'h81, 1'b1);
    tick(1);
    check("r81_data", RX_DATA, 8'h81);
    check("r81_valid", RX_VALID, 1'b1);
    tick(2);

    // random frames, gaps, stop bits, ready and clear pulses
    rnd_on = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      bit         stopb;
      b     = 8'($urandom);
      stopb = ($urandom_range(0, 7) != 0);
      send_frame(b, stopb);
      if (!stopb) begin
        RXD = 1'b1;
        tick($urandom_range(1, 6));
      end else begin
        tick($urandom_range(0, 5));
      end
    end
    RXD = 1'b1;
    rnd_on = 1'b0;
    tick(2);
    RX_READY = 1'b1;
    ERR_CLR = 1'b0;
    tick(60);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, truncated; CLKS_PER_BIT SHALL be >= 4, behaviour below 4 undefined.
REQ-003 CLK  input  1  single system clock, all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 RXD  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 RX_DATA  output  8  received byte, valid while RX_VALID=1.
REQ-007 RX_VALID  output  1  byte available in output buffer.
REQ-008 RX_READY  input  1  consumer accepts byte; transfer on edge with RX_VALID=1 and RX_READY=1.
REQ-009 FRAME_ERR  output  1  sticky: stop bit sampled low.
REQ-010 OVERRUN  output  1  sticky: completed byte dropped because buffer full.
REQ-011 ERR_CLR  input  1  single-cycle pulse clearing FRAME_ERR and OVERRUN.
REQ-012 BUSY  output  1  high in any state other than IDLE.

Function
REQ-013 RXD SHALL pass through a two-flop synchronizer; all sampling uses the synchronized value (rxs), giving 2 cycles input latency.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE; one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-015 IDLE: on rxs=0, go START, clear counter.
REQ-016 START: when counter reaches CLKS_PER_BIT/2-1 (mid start bit), sample rxs; rxs=1 -> IDLE (glitch rejected, no flags); rxs=0 -> DATA, clear counter and bit index.
REQ-017 DATA: each time counter reaches CLKS_PER_BIT-1, sample rxs into shift register bit [index], clear counter; after index 7 go STOP.
REQ-018 STOP: when counter reaches CLKS_PER_BIT-1, sample rxs; rxs=1 -> deliver byte (REQ-020), go IDLE; rxs=0 -> set FRAME_ERR, discard byte, go WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rxs=1, then IDLE; a low line after a framing error SHALL NOT start a new frame.
REQ-020 Delivery: on the edge after the stop-bit sample, RX_DATA loads shift register and RX_VALID=1, unless buffer full (REQ-022).
REQ-021 RX_VALID and RX_DATA SHALL hold stable until the handshake edge; RX_VALID then clears unless REQ-023 applies.
REQ-022 Delivery while RX_VALID=1 and RX_READY=0: new byte dropped, RX_DATA unchanged, OVERRUN set.
REQ-023 Delivery on the same edge as handshake: new byte loaded, RX_VALID stays 1, no OVERRUN.
REQ-024 ERR_CLR coinciding with a flag set event: set wins.
REQ-025 Receiver SHALL keep receiving while RX_VALID=1; buffer state never stalls the state machine.

Reset
REQ-026 RESET=1 on a clock edge SHALL force IDLE, counter=0, index=0, synchronizer flops=1, RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
REQ-027 RESET mid-frame SHALL abort the frame without delivery or flags; after release, a low line is treated as a new start bit.
REQ-028 RESET SHALL override RX_READY, ERR_CLR and RXD.

Verification (bench: CLK_FREQ_HZ=1_000_000, BAUD_RATE=250_000 -> CLKS_PER_BIT=4)
REQ-029 Send 0xA5 8N1, RX_READY=1 -> RX_VALID one cycle with RX_DATA=8'hA5, FRAME_ERR=0, OVERRUN=0, BUSY low after stop sample.
REQ-030 RXD low for 1 cycle then high -> START rejects, returns IDLE, no RX_VALID, no flags.
REQ-031 Send 0x3C with stop bit low, then hold line low 12 cycles, then high -> FRAME_ERR=1, no RX_VALID, no new frame until line high; ERR_CLR pulse -> FRAME_ERR=0.
REQ-032 RX_READY=0, send 0x11 then 0x22 -> RX_DATA=8'h11 held, OVERRUN=1; raise RX_READY -> one transfer of 0x11, RX_VALID=0.
REQ-033 RX_READY=0, send 0x55, assert RX_READY exactly on delivery edge of a following 0x66 -> 0x55 transferred, RX_DATA=8'h66, RX_VALID=1, OVERRUN=0.
REQ-034 Assert RESET during DATA bit 4 of 0xFF -> all outputs at reset values, no delivery; subsequent 0x81 received correctly.
